pick_place_seq: RTL

- Command sequencer that sits directly upstream of the arm top-level.
- Accepts a single pick command: a target coordinate in Q16.16 cm, relative to joint 1.
- Drives the arm through a fixed sequence: move to target, grip, move to drop point, release, return to preset home angles.
- Generates the arm's x, y, en1, en2, set_xita1, set_xita2 and catch inputs. Uses fixed dwell timers instead of feedback, because the arm provides no position status.

---
 rtl/pick_place_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pick_place_seq.sv
`default_nettype none
// ============================================================================
// Module      : pick_place_seq
// Description : Open-loop pick-and-place command sequencer for the two-joint
//               arm. A single pick command (Q16.16 cm target relative to
//               joint 1) drives the arm through MOVE_PICK -> GRIP ->
//               MOVE_DROP -> RELEASE -> HOME using fixed dwell timers, since
//               the arm reports no position status.
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               start, abort        command strobe / abandon sequence
//               tgt_x, tgt_y        pick coordinate, Q16.16 signed
//               x, y, en1, en2      arm coordinate and mode enables
//               set_xita1/2         forced joint angles (constant home)
//               catch               gripper close
//               busy, done, err,    status: in progress, completion pulse,
//               aborted             rejected-command pulse, abort pulse
//               state               current state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module pick_place_seq #(
  parameter logic [31:0] MOVE_CYC   = 32'd25_000_000,
  parameter logic [31:0] GRIP_CYC   = 32'd15_000_000,
  parameter logic [31:0] DROP_X     = 32'h000A_0000,
  parameter logic [31:0] DROP_Y     = 32'h0000_0000,
  parameter logic [31:0] HOME_XITA1 = 32'h005A_0000,
  parameter logic [31:0] HOME_XITA2 = 32'h005A_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] tgt_x,
  input  logic [31:0] tgt_y,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic        en1,
  output logic        en2,
  output logic [31:0] set_xita1,
  output logic [31:0] set_xita2,
  output logic        catch,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted,
  output logic [2:0]  state
);

  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_MOVE_PICK = 3'd1;
  localparam logic [2:0] c_S_GRIP      = 3'd2;
  localparam logic [2:0] c_S_MOVE_DROP = 3'd3;
  localparam logic [2:0] c_S_RELEASE   = 3'd4;
  localparam logic [2:0] c_S_HOME      = 3'd5;

  // Reload values: a state lasts exactly N cycles when loaded with N-1 and
  // left on the cycle the counter reads zero.
  localparam logic [31:0] c_MOVE_LOAD = MOVE_CYC - 32'd1;
  localparam logic [31:0] c_GRIP_LOAD = GRIP_CYC - 32'd1;

  logic [31:0] r_timer;
  logic        r_home_via_abort;   // suppresses done at the end of this HOME

  logic w_timer_zero;
  logic w_tgt_ok;
  logic w_abortable;

  assign w_timer_zero = (r_timer == 32'd0);
  // Negative coordinates lie behind joint 1 and are rejected outright.
  assign w_tgt_ok     = ~tgt_x[31] & ~tgt_y[31];
  assign w_abortable  = (state == c_S_MOVE_PICK) || (state == c_S_GRIP) ||
                        (state == c_S_MOVE_DROP) || (state == c_S_RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= c_S_IDLE;
      x                <= 32'd0;
      y                <= 32'd0;
      en1              <= 1'b0;
      en2              <= 1'b1;
      set_xita1        <= HOME_XITA1;
      set_xita2        <= HOME_XITA2;
      catch            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      aborted          <= 1'b0;
      r_timer          <= 32'd0;
      r_home_via_abort <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
      set_xita1 <= HOME_XITA1;
      set_xita2 <= HOME_XITA2;

      // Free-running decrement; any state change below overrides it.
      if (!w_timer_zero) begin
        r_timer <= r_timer - 32'd1;
      end

      if (w_abortable && abort) begin
        // Abort always goes straight home with the gripper opened.
        state            <= c_S_HOME;
        r_timer          <= c_MOVE_LOAD;
        catch            <= 1'b0;
        en1              <= 1'b0;
        en2              <= 1'b1;
        aborted          <= 1'b1;
        r_home_via_abort <= 1'b1;
      end else begin
        case (state)
          c_S_IDLE: begin
            // Abort takes precedence over a simultaneous start.
            if (start && !abort) begin
              if (!w_tgt_ok) begin
                err <= 1'b1;
              end else begin
                x                <= tgt_x;
                y                <= tgt_y;
                state            <= c_S_MOVE_PICK;
                r_timer          <= c_MOVE_LOAD;
                en1              <= 1'b1;
                en2              <= 1'b0;
                catch            <= 1'b0;
                busy             <= 1'b1;
                r_home_via_abort <= 1'b0;
              end
            end
          end
          c_S_MOVE_PICK: begin
            if (w_timer_zero) begin
              state   <= c_S_GRIP;
              r_timer <= c_GRIP_LOAD;
              catch   <= 1'b1;
            end
          end
          c_S_GRIP: begin
            if (w_timer_zero) begin
              state   <= c_S_MOVE_DROP;
              r_timer <= c_MOVE_LOAD;
              x       <= DROP_X;
              y       <= DROP_Y;
            end
          end
          c_S_MOVE_DROP: begin
            if (w_timer_zero) begin
              state   <= c_S_RELEASE;
              r_timer <= c_GRIP_LOAD;
              catch   <= 1'b0;
            end
          end
          c_S_RELEASE: begin
            if (w_timer_zero) begin
              state   <= c_S_HOME;
              r_timer <= c_MOVE_LOAD;
              en1     <= 1'b0;
              en2     <= 1'b1;
            end
          end
          c_S_HOME: begin
            if (w_timer_zero) begin
              state            <= c_S_IDLE;
              busy             <= 1'b0;
              done             <= ~r_home_via_abort;
              r_home_via_abort <= 1'b0;
            end
          end
          default: begin
            // Unreachable codes fall back to a safe idle posture.
            state   <= c_S_IDLE;
            r_timer <= 32'd0;
            en1     <= 1'b0;
            en2     <= 1'b1;
            catch   <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
